noc_output_scheduler: RTL and testbench
=======================================

Name: noc_output_scheduler

Overview:
- Clocked 5:1 output-port scheduler for the SNN NoC router.
- Shares one 51-bit output link between the up, down, left, right and local requesters.
- Arbitration is round-robin with a bounded burst, so that consecutive packets from one source can stay together.
- One output register sits between the arbiter and the link; valid/ready handshakes on every side.

Parameters:
- N_PORTS, 5, number of requesters (index 0=up, 1=down, 2=left, 3=right, 4=local).
- PACK_WIDTH, 51, packet width in bits.
- MAX_BURST, 4, maximum consecutive accepts granted to one holder; 1 gives pure round-robin.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  N_PORTS  per-port packet valid.
- in_data  in  N_PORTS*PACK_WIDTH  packed per-port packets; port i occupies bits [i*PACK_WIDTH +: PACK_WIDTH].
- in_ready  out  N_PORTS  one-hot (or zero) accept strobe.
- out_valid  out  1  output register holds a packet.
- out_data  out  PACK_WIDTH  registered packet.
- out_src  out  3  index of the port that supplied out_data.
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0, out_data=0, out_src=0.
  - ptr=0, holder=0, hold_active=0, burst_cnt=0.
  - in_ready is forced to 0 while rst=1.
  - Reset mid-transfer drops the registered packet; the upstream sees no accept that cycle.
- can_load = !out_valid || out_ready.
- Winner selection (combinational):
  - Hold path: if hold_active && in_valid[holder] && burst_cnt < MAX_BURST, then winner=holder.
  - Otherwise, scan path: winner is the first i with in_valid[i], scanning ptr, ptr+1, …, ptr+N-1 mod N_PORTS.
  - If no input is valid, there is no winner.
- in_ready[winner] = can_load && winner exists && !rst. All other in_ready bits are 0. in_ready must not depend on in_data.
- Accept: in_valid[w] && in_ready[w]. On accept, at the edge:
  - out_data <= in_data[w], out_src <= w, out_valid <= 1.
  - ptr <= (w+1) mod N_PORTS, with wrap 4 -> 0.
  - Hold path: burst_cnt <= burst_cnt+1.
  - Scan path: holder <= w, burst_cnt <= 1.
  - hold_active <= 1.
- No accept but out_ready && out_valid: out_valid <= 0. out_data and out_src hold their old values.
- Stall (out_valid && !out_ready): all in_ready=0; ptr, holder and burst state are frozen.
- Simultaneous drain and load: out_ready=1 with a pending winner means the register is refilled in the same cycle, so full throughput is 1 packet/cycle.
- Burst exhausted: once burst_cnt==MAX_BURST the scan path is used. Because ptr = holder+1, other requesters come first. If the holder is the sole requester it wins via scan and burst_cnt restarts at 1.
- Holder drops in_valid: the next selection uses the scan path immediately. There is no idle cycle.
- Fairness bound: with all ports continuously valid, any port waits at most (N_PORTS-1)*MAX_BURST accepts.
- Latency: accept at edge k gives out_valid=1 after edge k. This is 1 cycle from in_valid to out_valid when the register is free.
- No packet is duplicated or dropped outside reset.

Decomposition:
- Shared package snn_noc_pkg:
  - PACK_WIDTH=51, N_PORTS=5.
  - Port-index enum PORT_UP=0, PORT_DOWN=1, PORT_LEFT=2, PORT_RIGHT=3, PORT_LOCAL=4.
  - Packet typedef logic [PACK_WIDTH-1:0].
- Sub-module rr_pick: combinational rotating priority encoder.
  - Inputs: req[N], ptr.
  - Outputs: found, idx.
  - Instantiated once for the scan path.

Test Plan:
- Reset then idle: rst high 2 cycles with in_valid=5'b11111 -> in_ready=0 and out_valid=0 throughout; after release, the first accept is port 0.
- Single local requester: in_valid=5'b10000 with data 51'h1A5, out_ready=1 -> in_ready[4]=1, next cycle out_valid=1, out_data=51'h1A5, out_src=4; 6 back-to-back packets give 1/cycle throughput, with burst_cnt restarting after 4.
- All ports valid, MAX_BURST=1, out_ready=1 -> out_src sequence 0,1,2,3,4,0,1 on consecutive cycles.
- All ports valid, MAX_BURST=4 -> out_src sequence 0,0,0,0,1,1,1,1,2,…; deassert in_valid[1] after its 2nd packet -> the next source is 2 with no bubble.
- Backpressure: out_ready=0 for 5 cycles while port 3 is valid -> in_ready=0 for all ports, out_data is stable, ptr is unchanged; out_ready=1 -> the pending packet drains and port 3 loads in the same cycle.
- Reset mid-burst: assert rst during the 3rd packet of port 2's burst -> out_valid=0 next cycle; after release, selection restarts from ptr=0 (port 0 wins if valid).

Source files
------------

// File: rtl/snn_noc_pkg.sv
// Shared SNN NoC definitions: link geometry, port indices and packet type.
package snn_noc_pkg;

    localparam int PACK_WIDTH = 51;
    localparam int N_PORTS    = 5;

    typedef enum logic [2:0] {
        PORT_UP    = 3'd0,
        PORT_DOWN  = 3'd1,
        PORT_LEFT  = 3'd2,
        PORT_RIGHT = 3'd3,
        PORT_LOCAL = 3'd4
    } port_e;

    typedef logic [PACK_WIDTH-1:0] packet_t;

    // Successor port index, wrapping the last port back to 0.
    function automatic logic [2:0] next_port(input logic [2:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return 3'd0;
        end else begin
            return idx + 3'd1;
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 5,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);

    logic [PW:0] cand_s;

    // Walk the N candidates in rotated order and keep the first requester.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        cand_s = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = (PW+1)'(ptr) + (PW+1)'(k);
            if (cand_s >= (PW+1)'(N)) begin
                cand_s = cand_s - (PW+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!found && req[cand_s[PW-1:0]]) begin
                found = 1'b1;
                idx   = cand_s[PW-1:0];
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/noc_output_scheduler.sv
// 5:1 output-port scheduler: round-robin with bounded bursts feeding one registered link.
module noc_output_scheduler
    import snn_noc_pkg::*;
#(
    parameter int N_PORTS    = snn_noc_pkg::N_PORTS,
    parameter int PACK_WIDTH = snn_noc_pkg::PACK_WIDTH,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            in_valid,
    input  logic [N_PORTS*PACK_WIDTH-1:0] in_data,
    output logic [N_PORTS-1:0]            in_ready,
    output logic                          out_valid,
    output logic [PACK_WIDTH-1:0]         out_data,
    output logic [2:0]                    out_src,
    input  logic                          out_ready
);

    localparam int BW = $clog2(MAX_BURST + 1);

    logic [2:0]            ptr_q, ptr_d;
    logic [2:0]            holder_q, holder_d;
    logic                  hold_active_q, hold_active_d;
    logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [PACK_WIDTH-1:0] out_data_q, out_data_d;
    logic [2:0]            out_src_q, out_src_d;

    logic       can_load_s, hold_ok_s, scan_found_s, found_s, accept_s;
    logic [2:0] scan_idx_s, winner_s;

    rr_pick #(.N(N_PORTS), .PW(3)) u_scan (
        .req   (in_valid),
        .ptr   (ptr_q),
        .found (scan_found_s),
        .idx   (scan_idx_s)
    );

    // Winner selection: the burst holder keeps priority until its budget is spent.
    always_comb begin
        can_load_s = !out_valid_q || out_ready;
        hold_ok_s  = hold_active_q && in_valid[holder_q] && (burst_cnt_q < BW'(MAX_BURST));
        found_s    = hold_ok_s || scan_found_s;
        winner_s   = hold_ok_s ? holder_q : scan_idx_s;
        accept_s   = can_load_s && found_s && !rst;
        in_ready   = '0;
        if (accept_s) begin
            in_ready[winner_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Next-state: load on accept, otherwise drain or hold the output register.
    always_comb begin
        ptr_d         = ptr_q;
        holder_d      = holder_q;
        hold_active_d = hold_active_q;
        burst_cnt_d   = burst_cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_src_d     = out_src_q;
        if (accept_s) begin
            out_valid_d   = 1'b1;
            out_data_d    = in_data[int'(winner_s)*PACK_WIDTH +: PACK_WIDTH];
            out_src_d     = winner_s;
            ptr_d         = next_port(winner_s, N_PORTS);
            hold_active_d = 1'b1;
            if (hold_ok_s) begin
                burst_cnt_d = burst_cnt_q + BW'(1);
            end else begin
                holder_d    = winner_s;
                burst_cnt_d = BW'(1);
            end
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= 3'd0;
            holder_q      <= 3'd0;
            hold_active_q <= 1'b0;
            burst_cnt_q   <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_src_q     <= PORT_UP;
        end else begin
            ptr_q         <= ptr_d;
            holder_q      <= holder_d;
            hold_active_q <= hold_active_d;
            burst_cnt_q   <= burst_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_src_q     <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_noc_output_scheduler.sv
// Bench: two schedulers (burst 4 and burst 1) against a queue-free behavioural arbitration model.
module tb_noc_output_scheduler;

    localparam int N = 5;
    localparam int W = 51;

    logic             clk = 1'b0;
    logic             rst;
    logic             out_ready;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     rdy0, rdy1;
    logic             ov0, ov1;
    logic [W-1:0]     od0, od1;
    logic [2:0]       os0, os1;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] obs_rdy [2];
    logic         obs_ov  [2];
    logic [W-1:0] obs_od  [2];
    logic [2:0]   obs_os  [2];
    logic [N-1:0] exp_rdy [2];

    int           lim    [2] = '{4, 1};
    int           m_ptr  [2];
    int           m_hold [2];
    int           m_cnt  [2];
    bit           m_act  [2];
    bit           m_ov   [2];
    logic [W-1:0] m_od   [2];
    int           m_os   [2];

    always #5 clk = ~clk;

    noc_output_scheduler #(.MAX_BURST(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
        .out_valid(ov0), .out_data(od0), .out_src(os0), .out_ready(out_ready)
    );

    noc_output_scheduler #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
        .out_valid(ov1), .out_data(od1), .out_src(os1), .out_ready(out_ready)
    );

    function automatic bit holder_keeps(int b);
        return m_act[b] && in_valid[m_hold[b]] && (m_cnt[b] < lim[b]);
    endfunction

    function automatic int choose(int b);
        if (holder_keeps(b)) return m_hold[b];
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr[b] + k) % N]) return (m_ptr[b] + k) % N;
        end
        return -1;
    endfunction

    task automatic set_port_data(int p);
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        in_data[p*W +: W] = t[W-1:0];
    endtask

    // One clock: predict in_ready, sample it, advance the model, sample registered outputs.
    task automatic tick();
        int  w   [2];
        bit  acc [2];
        bit  hk;
        @(negedge clk);
        obs_rdy[0] = rdy0;
        obs_rdy[1] = rdy1;
        for (int b = 0; b < 2; b++) begin
            w[b]       = choose(b);
            acc[b]     = !rst && (w[b] >= 0) && (!m_ov[b] || out_ready);
            exp_rdy[b] = '0;
            if (acc[b]) exp_rdy[b][w[b]] = 1'b1;
        end
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            if (rst) begin
                m_ptr[b] = 0; m_hold[b] = 0; m_cnt[b] = 0; m_act[b] = 0;
                m_ov[b] = 0; m_od[b] = '0; m_os[b] = 0;
            end else if (acc[b]) begin
                hk       = holder_keeps(b);
                m_od[b]  = in_data[w[b]*W +: W];
                m_os[b]  = w[b];
                m_ov[b]  = 1;
                m_ptr[b] = (w[b] + 1) % N;
                m_act[b] = 1;
                if (hk) begin
                    m_cnt[b] = m_cnt[b] + 1;
                end else begin
                    m_hold[b] = w[b];
                    m_cnt[b]  = 1;
                end
            end else if (out_ready && m_ov[b]) begin
                m_ov[b] = 0;
            end
        end
        #1;
        obs_ov[0] = ov0; obs_od[0] = od0; obs_os[0] = os0;
        obs_ov[1] = ov1; obs_od[1] = od1; obs_os[1] = os1;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; in_valid = 5'b11111;
        for (int p = 0; p < N; p++) set_port_data(p);
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int b = 0; b < 2; b++) begin
                checks++;
                if (obs_rdy[b] !== 5'b00000 || obs_ov[b] !== 1'b0 || obs_od[b] !== '0 || obs_os[b] !== 3'd0) begin
                    failures++;
                    $display("FAIL reset dut%0d: rdy=%b ov=%b od=%h os=%0d, want rdy=00000 ov=0 od=0 os=0",
                             b, obs_rdy[b], obs_ov[b], obs_od[b], obs_os[b]);
                end
            end
        end
        rst = 1'b0;
        tick();
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (obs_rdy[b] !== 5'b00001 || obs_ov[b] !== 1'b1 || obs_os[b] !== 3'd0 || obs_od[b] !== in_data[0 +: W]) begin
                failures++;
                $display("FAIL first_accept dut%0d: rdy=%b ov=%b os=%0d od=%h, want rdy=00001 ov=1 os=0 od=%h",
                         b, obs_rdy[b], obs_ov[b], obs_os[b], obs_od[b], in_data[0 +: W]);
            end
        end
    endtask

    task automatic test_single_local();
        logic [W-1:0] d;
        in_valid = 5'b10000; out_ready = 1'b1;
        in_data[4*W +: W] = 51'h1A5;
        for (int c = 0; c < 7; c++) begin
            d = in_data[4*W +: W];
            tick();
            for (int b = 0; b < 2; b++) begin
                checks++;
                if (obs_rdy[b] !== 5'b10000 || obs_ov[b] !== 1'b1 || obs_os[b] !== 3'd4 || obs_od[b] !== d) begin
                    failures++;
                    $display("FAIL local pkt%0d dut%0d: rdy=%b ov=%b os=%0d od=%h, want rdy=10000 ov=1 os=4 od=%h",
                             c, b, obs_rdy[b], obs_ov[b], obs_os[b], obs_od[b], d);
                end
            end
            set_port_data(4);
        end
    endtask

    task automatic test_round_robin();
        int seq1 [7] = '{0, 1, 2, 3, 4, 0, 1};
        int seq4 [7] = '{0, 0, 0, 0, 1, 1, 1};
        rst = 1'b1; tick(); rst = 1'b0;
        in_valid = 5'b11111; out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            checks++;
            if (obs_ov[1] !== 1'b1 || int'(obs_os[1]) != seq1[c]) begin
                failures++;
                $display("FAIL rr_burst1 step%0d: ov=%b os=%0d, want ov=1 os=%0d", c, obs_ov[1], obs_os[1], seq1[c]);
            end
            checks++;
            if (obs_ov[0] !== 1'b1 || int'(obs_os[0]) != seq4[c]) begin
                failures++;
                $display("FAIL rr_burst4 step%0d: ov=%b os=%0d, want ov=1 os=%0d", c, obs_ov[0], obs_os[0], seq4[c]);
            end
            for (int p = 0; p < N; p++) set_port_data(p);
        end
    endtask

    task automatic test_burst_drop();
        int seq4 [11] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 3};
        int seq1 [11] = '{0, 1, 2, 3, 4, 0, 2, 3, 4, 0, 2};
        rst = 1'b1; tick(); rst = 1'b0;
        in_valid = 5'b11111; out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            tick();
            checks++;
            if (obs_ov[0] !== 1'b1 || int'(obs_os[0]) != seq4[c]) begin
                failures++;
                $display("FAIL burst_drop4 step%0d: ov=%b os=%0d, want ov=1 os=%0d", c, obs_ov[0], obs_os[0], seq4[c]);
            end
            checks++;
            if (obs_ov[1] !== 1'b1 || int'(obs_os[1]) != seq1[c]) begin
                failures++;
                $display("FAIL burst_drop1 step%0d: ov=%b os=%0d, want ov=1 os=%0d", c, obs_ov[1], obs_os[1], seq1[c]);
            end
            if (c == 5) in_valid = 5'b11101;
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        logic [W-1:0] fresh;
        in_valid = 5'b01000; out_ready = 1'b1;
        set_port_data(3);
        tick();
        held = in_data[3*W +: W];
        out_ready = 1'b0;
        set_port_data(3);
        fresh = in_data[3*W +: W];
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int b = 0; b < 2; b++) begin
                checks++;
                if (obs_rdy[b] !== 5'b00000 || obs_ov[b] !== 1'b1 || obs_od[b] !== held || obs_os[b] !== 3'd3) begin
                    failures++;
                    $display("FAIL stall c%0d dut%0d: rdy=%b ov=%b od=%h os=%0d, want rdy=00000 ov=1 od=%h os=3",
                             c, b, obs_rdy[b], obs_ov[b], obs_od[b], obs_os[b], held);
                end
            end
        end
        out_ready = 1'b1;
        tick();
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (obs_rdy[b] !== 5'b01000 || obs_ov[b] !== 1'b1 || obs_od[b] !== fresh) begin
                failures++;
                $display("FAIL drain_and_load dut%0d: rdy=%b ov=%b od=%h, want rdy=01000 ov=1 od=%h",
                         b, obs_rdy[b], obs_ov[b], obs_od[b], fresh);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        rst = 1'b1; tick(); rst = 1'b0;
        in_valid = 5'b00100; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        checks++;
        if (obs_rdy[0] !== 5'b00000 || obs_ov[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: rdy=%b ov=%b, want rdy=00000 ov=0", obs_rdy[0], obs_ov[0]);
        end
        rst = 1'b0; in_valid = 5'b11111;
        tick();
        checks++;
        if (obs_rdy[0] !== 5'b00001 || obs_os[0] !== 3'd0 || obs_ov[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_restart: rdy=%b os=%0d ov=%b, want rdy=00001 os=0 ov=1",
                     obs_rdy[0], obs_os[0], obs_ov[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = N'($urandom());
            for (int p = 0; p < N; p++) set_port_data(p);
            tick();
            for (int b = 0; b < 2; b++) begin
                checks++;
                if (obs_rdy[b] !== exp_rdy[b] || obs_ov[b] !== m_ov[b] || obs_od[b] !== m_od[b] || int'(obs_os[b]) != m_os[b]) begin
                    failures++;
                    $display("FAIL random c%0d dut%0d: rdy=%b ov=%b od=%h os=%0d, want rdy=%b ov=%b od=%h os=%0d",
                             c, b, obs_rdy[b], obs_ov[b], obs_od[b], obs_os[b],
                             exp_rdy[b], m_ov[b], m_od[b], m_os[b]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0; in_valid = '0; in_data = '0;
        for (int b = 0; b < 2; b++) begin
            m_ptr[b] = 0; m_hold[b] = 0; m_cnt[b] = 0; m_act[b] = 0;
            m_ov[b] = 0; m_od[b] = '0; m_os[b] = 0;
        end
        test_reset();
        test_single_local();
        test_round_robin();
        test_burst_drop();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
